ternary_seq_ctrl: RTL

TERNARY_SEQ_CTRL -- requirements
Module: ternary_seq_ctrl

---
 rtl/ternary_seq_ctrl_pkg.sv | 24 ++
 rtl/ternary_seq_ctrl_if.sv | 27 ++
 rtl/ternary_seq_ctrl_seq_counter.sv | 29 ++
 rtl/ternary_seq_ctrl.sv | 114 +++++++++++
 4 files changed

// File: rtl/ternary_seq_ctrl_pkg.sv
// Shared types and constants for the ternary sequencer: state encoding,
// default geometry and the derived weight-load length.
package ternary_seq_ctrl_pkg;

  localparam int DEF_MAX_IN_LEN   = 12;
  localparam int DEF_MAX_OUT_LEN  = 12;
  localparam int DEF_WEIGHT_WIDTH = 2;
  localparam int BIT_WIDTH        = 16;
  localparam int LOAD_CYCLES      = DEF_WEIGHT_WIDTH * DEF_MAX_OUT_LEN;
  localparam int VEC_W            = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_COMPUTE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  // Counter width that still works for a modulus of 1.
  function automatic int cnt_width(input int modulus);
    return (modulus <= 1) ? 1 : $clog2(modulus);
  endfunction

endpackage

// File: rtl/ternary_seq_ctrl_if.sv
// Job request / status bundle between a host and the ternary sequencer.
interface ternary_seq_ctrl_if;
  import ternary_seq_ctrl_pkg::*;

  logic             start;
  logic             reload;
  logic [VEC_W-1:0] num_vec;
  logic             hold;
  logic             load_ena;
  logic             lsb_select;
  logic             busy;
  logic             out_valid;
  logic             done;
  logic             wts_loaded;
  logic [VEC_W-1:0] vec_idx;

  modport master (
    output start, reload, num_vec, hold,
    input  load_ena, lsb_select, busy, out_valid, done, wts_loaded, vec_idx
  );

  modport slave (
    input  start, reload, num_vec, hold,
    output load_ena, lsb_select, busy, out_valid, done, wts_loaded, vec_idx
  );

endinterface

// File: rtl/ternary_seq_ctrl_seq_counter.sv
// Modulo-MAX up-counter with synchronous clear, count enable and a
// terminal flag that is high while the count sits at MAX-1.
module seq_counter #(
  parameter int MAX = 16,
  parameter int W   = ternary_seq_ctrl_pkg::cnt_width(MAX)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         last
);
  import ternary_seq_ctrl_pkg::*;

  logic [W-1:0] count_reg;

  assign last  = (count_reg == W'(MAX - 1));
  assign count = count_reg;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= last ? '0 : count_reg + W'(1);
    end
  end

endmodule

// File: rtl/ternary_seq_ctrl.sv
// Job sequencer for a bit-serial ternary matrix-vector unit: optional
// weight shift-load, then BIT_WIDTH cycles per input vector, then a done pulse.
module ternary_seq_ctrl #(
  parameter int MAX_IN_LEN   = ternary_seq_ctrl_pkg::DEF_MAX_IN_LEN,
  parameter int MAX_OUT_LEN  = ternary_seq_ctrl_pkg::DEF_MAX_OUT_LEN,
  parameter int WEIGHT_WIDTH = ternary_seq_ctrl_pkg::DEF_WEIGHT_WIDTH,
  parameter int BIT_WIDTH    = ternary_seq_ctrl_pkg::BIT_WIDTH
) (
  input logic               clk,
  input logic               rst,
  ternary_seq_ctrl_if.slave bus
);
  import ternary_seq_ctrl_pkg::*;

  localparam int LOAD_LEN = WEIGHT_WIDTH * MAX_OUT_LEN;
  localparam int LOAD_W   = cnt_width(LOAD_LEN);
  localparam int BIT_W    = cnt_width(BIT_WIDTH);

  localparam logic [1:0] IDLE    = ST_IDLE;
  localparam logic [1:0] LOAD    = ST_LOAD;
  localparam logic [1:0] COMPUTE = ST_COMPUTE;
  localparam logic [1:0] DONE    = ST_DONE;

  // Input length only shapes the datapath; the sequencer just needs it sane.
  if (MAX_IN_LEN > 0) begin : g_in_len_ok
  end

  logic [1:0]       state_reg, state_next;
  logic             wts_loaded_reg;
  logic [VEC_W-1:0] num_vec_reg;
  logic [VEC_W-1:0] vec_idx_reg;
  logic             ov_pend_reg;

  logic              load_en, bit_en;
  logic              load_last, bit_last;
  logic [LOAD_W-1:0] load_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic              load_done, vec_done, last_vec, start_ok;

  assign start_ok  = (state_reg == IDLE) && bus.start;
  assign load_en   = (state_reg == LOAD) && !bus.hold;
  assign bit_en    = (state_reg == COMPUTE) && !bus.hold;
  assign load_done = load_en && load_last;
  assign vec_done  = bit_en && bit_last;
  assign last_vec  = (vec_idx_reg == num_vec_reg - VEC_W'(1));

  seq_counter #(.MAX(LOAD_LEN), .W(LOAD_W)) u_load_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (state_reg != LOAD),
    .en    (load_en),
    .count (load_cnt),
    .last  (load_last)
  );

  seq_counter #(.MAX(BIT_WIDTH), .W(BIT_W)) u_bit_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (state_reg != COMPUTE),
    .en    (bit_en),
    .count (bit_cnt),
    .last  (bit_last)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          if (bus.reload || !wts_loaded_reg) state_next = LOAD;
          else if (bus.num_vec == '0)        state_next = DONE;
          else                               state_next = COMPUTE;
        end
      end
      LOAD: begin
        if (load_done) state_next = (num_vec_reg != '0) ? COMPUTE : DONE;
      end
      COMPUTE: begin
        if (vec_done && last_vec) state_next = DONE;
      end
      DONE: begin
        if (!bus.hold) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      wts_loaded_reg <= 1'b0;
      num_vec_reg    <= '0;
      vec_idx_reg    <= '0;
      ov_pend_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (start_ok)  num_vec_reg    <= bus.num_vec;
      if (load_done) wts_loaded_reg <= 1'b1;
      if ((state_reg == DONE) && !bus.hold) vec_idx_reg <= '0;
      else if (vec_done)                    vec_idx_reg <= vec_idx_reg + VEC_W'(1);
      // The finished-vector flag is held, not dropped, across a hold.
      if (!bus.hold) ov_pend_reg <= vec_done;
    end
  end

  assign bus.load_ena   = load_en;
  assign bus.lsb_select = bit_en && (bit_cnt == '0);
  assign bus.busy       = (state_reg != IDLE);
  assign bus.out_valid  = ov_pend_reg && !bus.hold;
  assign bus.done       = (state_reg == DONE) && !bus.hold;
  assign bus.wts_loaded = wts_loaded_reg;
  assign bus.vec_idx    = vec_idx_reg;

endmodule
